// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential non-restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int DIV_W_DEFAULT = 32;
    localparam int DIV_W_MAX     = 128;

    // Magnitude of a sign-extended two's complement value; the most negative
    // N-bit value maps to 2^(N-1), which still fits an unsigned N-bit field.
    function automatic logic [DIV_W_MAX-1:0] abs_val(input logic [DIV_W_MAX-1:0] x);
        return x[DIV_W_MAX-1] ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/div_addsub.sv
// (W)-bit add/subtract stage shared by the iteration and the final remainder fix-up.
module div_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic [W-1:0] o_sum
);

    assign o_sum = i_sub ? (i_a - i_b) : (i_a + i_b);

endmodule

// File: rtl/seq_divider.sv
// Iterative non-restoring divider, one quotient bit per clock.
// Define SEQ_DIV_SIGNED_EN for two's complement operands; unsigned otherwise.
module seq_divider
    import div_pkg::*;
#(
    parameter int N = DIV_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic [N-1:0] o_quotient,
    output logic [N-1:0] o_remainder,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_div_by_zero
);

    localparam int CW = $clog2(N) + 1;

    div_state_t    r_state;
    logic [N:0]    r_a;
    logic [N-1:0]  r_q;
    logic [N-1:0]  r_m;
    logic [CW-1:0] r_count;

    logic          w_accept;
    logic [N:0]    w_a_shift;
    logic [N:0]    w_add_a;
    logic          w_add_sub;
    logic [N:0]    w_sum;
    logic [N-1:0]  w_rem_mag;
    logic [N-1:0]  w_dvd_mag;
    logic [N-1:0]  w_dvs_mag;
    logic [N-1:0]  w_q_final;
    logic [N-1:0]  w_r_final;

    assign w_accept  = i_start && ((r_state == IDLE) || (r_state == DONE));
    assign w_a_shift = {r_a[N-1:0], r_q[N-1]};

    // CALC adds or subtracts on the shifted accumulator; FIX only ever adds M back.
    assign w_add_a   = (r_state == FIX) ? r_a : w_a_shift;
    assign w_add_sub = (r_state == FIX) ? 1'b0 : ~r_a[N];

    div_addsub #(.W(N + 1)) u_addsub (
        .i_a   (w_add_a),
        .i_b   ({1'b0, r_m}),
        .i_sub (w_add_sub),
        .o_sum (w_sum)
    );

    assign w_rem_mag = r_a[N] ? w_sum[N-1:0] : r_a[N-1:0];

`ifdef SEQ_DIV_SIGNED_EN
    logic r_q_neg;
    logic r_r_neg;

    assign w_dvd_mag = N'(abs_val(DIV_W_MAX'($signed(i_dividend))));
    assign w_dvs_mag = N'(abs_val(DIV_W_MAX'($signed(i_divisor))));
    assign w_q_final = r_q_neg ? (~r_q + 1'b1) : r_q;
    assign w_r_final = r_r_neg ? (~w_rem_mag + 1'b1) : w_rem_mag;
`else
    assign w_dvd_mag = i_dividend;
    assign w_dvs_mag = i_divisor;
    assign w_q_final = r_q;
    assign w_r_final = w_rem_mag;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_a           <= '0;
            r_q           <= '0;
            r_m           <= '0;
            r_count       <= '0;
            o_quotient    <= '0;
            o_remainder   <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_div_by_zero <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            r_q_neg       <= 1'b0;
            r_r_neg       <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
            unique case (r_state)
                IDLE, DONE: begin
                    r_state <= IDLE;
                    if (w_accept) begin
                        if (i_divisor == '0) begin
                            // Divide-by-zero bypasses the iteration entirely.
                            r_state       <= DONE;
                            o_done        <= 1'b1;
                            o_quotient    <= '1;
                            o_remainder   <= i_dividend;
                            o_div_by_zero <= 1'b1;
                        end else begin
                            r_state       <= CALC;
                            r_a           <= '0;
                            r_q           <= w_dvd_mag;
                            r_m           <= w_dvs_mag;
                            r_count       <= '0;
                            o_busy        <= 1'b1;
                            o_div_by_zero <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
                            r_q_neg       <= i_dividend[N-1] ^ i_divisor[N-1];
                            r_r_neg       <= i_dividend[N-1];
`endif
                        end
                    end
                end
                CALC: begin
                    r_a     <= w_sum;
                    r_q     <= {r_q[N-2:0], ~w_sum[N]};
                    r_count <= r_count + 1'b1;
                    if (r_count == CW'(N - 1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    o_quotient  <= w_q_final;
                    o_remainder <= w_r_final;
                    o_busy      <= 1'b0;
                    o_done      <= 1'b1;
                    r_state     <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (N=32), table vectors + random ops vs. an arithmetic model.
module tb_seq_divider;

    localparam int N         = 32;
    localparam int LAT_NORM  = N + 2;
    localparam int LAT_LIMIT = 100;

    logic          clk;
    logic          rst_n;
    logic          i_start;
    logic [N-1:0]  i_dividend;
    logic [N-1:0]  i_divisor;
    logic [N-1:0]  o_quotient;
    logic [N-1:0]  o_remainder;
    logic          o_busy;
    logic          o_done;
    logic          o_div_by_zero;

    int checks = 0;
    int errors = 0;
    int op_no  = 0;

    seq_divider #(.N(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .i_dividend    (i_dividend),
        .i_divisor     (i_divisor),
        .o_quotient    (o_quotient),
        .o_remainder   (o_remainder),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_div_by_zero (o_div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer division semantics of the configured build.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic dbz);
        longint sa, sb, sq, sr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            dbz = 1'b1;
        end else begin
`ifdef SEQ_DIV_SIGNED_EN
            sa = longint'($signed(a));
            sb = longint'($signed(b));
`else
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
`endif
            sq = sa / sb;
            sr = sa % sb;
            q = 32'(sq);
            r = 32'(sr);
            dbz = 1'b0;
        end
    endtask

    // Issues one operation; start asserted before the accept edge. Optionally
    // pulses a 9/3 start while the divider is busy (glitch = loop cycle index).
    task automatic run_op(input logic [31:0] dvd, input logic [31:0] dvs, input int glitch,
                          output logic [31:0] q, output logic [31:0] r, output logic dbz,
                          output int lat, output logic busy_ok);
        i_dividend = dvd;
        i_divisor  = dvs;
        i_start    = 1'b1;
        @(posedge clk); #1;
        i_start    = 1'b0;
        i_dividend = $urandom;
        i_divisor  = $urandom;
        lat     = 1;
        busy_ok = 1'b1;
        while (!o_done && lat < LAT_LIMIT) begin
            if (!o_busy) busy_ok = 1'b0;
            if (lat == glitch) begin
                i_start    = 1'b1;
                i_dividend = 32'd9;
                i_divisor  = 32'd3;
            end else begin
                i_start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        i_start = 1'b0;
        if (o_busy) busy_ok = 1'b0;
        q   = o_quotient;
        r   = o_remainder;
        dbz = o_div_by_zero;
    endtask

    task automatic verify(input string tag, input logic [31:0] dvd, input logic [31:0] dvs,
                          input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                          input logic [31:0] q, input logic [31:0] r, input logic dbz,
                          input int lat, input logic busy_ok);
        int exp_lat;
        exp_lat = (dvs == 32'd0) ? 1 : LAT_NORM;
        op_no++;
        $display("op %0d [%s]: %h / %h -> q=%h r=%h dbz=%0d lat=%0d busy_ok=%0d",
                 op_no, tag, dvd, dvs, q, r, dbz, lat, busy_ok);
        check({tag, " quotient"},  64'(q), 64'(eq));
        check({tag, " remainder"}, 64'(r), 64'(er));
        check({tag, " div_by_zero"}, 64'(dbz), 64'(edbz));
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " busy"}, 64'(busy_ok), 64'(1'b1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [31:0] q, r, eq, er, a, b;
        logic        dbz, edbz, busy_ok, saw_done;
        int          lat;

        vecs[0] = '{32'd100,  32'd7,  32'd14,  32'd2,  1'b0};
        vecs[1] = '{32'd55,   32'd0,  32'hFFFF_FFFF, 32'd55, 1'b1};
        vecs[2] = '{32'd1000, 32'd33, 32'd30,  32'd10, 1'b0};
        vecs[3] = '{32'd0,    32'd5,  32'd0,   32'd0,  1'b0};
        vecs[4] = '{32'd5,    32'd7,  32'd0,   32'd5,  1'b0};
        vecs[5] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0};
`ifdef SEQ_DIV_SIGNED_EN
        vecs[6] = '{32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0};
        vecs[7] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0};
        vecs[8] = '{32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0};
        vecs[9] = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0};
`else
        vecs[6] = '{32'hFFFF_FF9C, 32'd7, 32'h2492_4916, 32'd2, 1'b0};
        vecs[7] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0};
        vecs[8] = '{32'd7, 32'hFFFF_FFFE, 32'd0, 32'd7, 1'b0};
        vecs[9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd1, 1'b0};
`endif

        rst_n      = 1'b0;
        i_start    = 1'b0;
        i_dividend = '0;
        i_divisor  = '0;
        #12;
        check("reset quotient",  64'(o_quotient),  64'd0);
        check("reset remainder", 64'(o_remainder), 64'd0);
        check("reset busy",      64'(o_busy),      64'd0);
        check("reset done",      64'(o_done),      64'd0);
        check("reset dbz",       64'(o_div_by_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table vectors; 55/0 is followed by a valid op that must clear the flag.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].dvd, vecs[i].dvs, 0, q, r, dbz, lat, busy_ok);
            verify("vec", vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, vecs[i].dbz,
                   q, r, dbz, lat, busy_ok);
            idle(1);
        end

        // Start while busy is ignored; start in the DONE cycle is accepted back-to-back.
        run_op(32'd100, 32'd7, 5, q, r, dbz, lat, busy_ok);
        verify("busy_start", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, q, r, dbz, lat, busy_ok);
        run_op(32'd9, 32'd3, 0, q, r, dbz, lat, busy_ok);
        verify("b2b", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, q, r, dbz, lat, busy_ok);
        @(posedge clk); #1;
        check("b2b done single pulse", 64'(o_done), 64'd0);
        check("b2b idle busy", 64'(o_busy), 64'd0);

        // Divide-by-zero back-to-back with a valid op in its DONE cycle.
        run_op(32'd55, 32'd0, 0, q, r, dbz, lat, busy_ok);
        verify("dbz_b2b", 32'd55, 32'd0, 32'hFFFF_FFFF, 32'd55, 1'b1, q, r, dbz, lat, busy_ok);
        run_op(32'd100, 32'd7, 0, q, r, dbz, lat, busy_ok);
        verify("after_dbz", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, q, r, dbz, lat, busy_ok);
        idle(1);

        // Reset mid-calculation (counter at 10): outputs clear immediately, no done.
        i_dividend = 32'd12345;
        i_divisor  = 32'd3;
        i_start    = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        idle(10);
        check("pre-reset busy", 64'(o_busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset quotient",  64'(o_quotient),  64'd0);
        check("async reset remainder", 64'(o_remainder), 64'd0);
        check("async reset busy",      64'(o_busy),      64'd0);
        check("async reset done",      64'(o_done),      64'd0);
        check("async reset dbz",       64'(o_div_by_zero), 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (o_done) saw_done = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (o_done || o_busy) saw_done = 1'b1;
        end
        check("no done after abandoned op", 64'(saw_done), 64'd0);
        run_op(32'd1000, 32'd33, 0, q, r, dbz, lat, busy_ok);
        verify("post_reset", 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, q, r, dbz, lat, busy_ok);
        idle(1);

        // Random operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom_range(0, 20);
                1:       b = $urandom_range(0, 1) ? 32'hFFFF_FFFF - $urandom_range(0, 20) : 32'd1;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0) a = 32'h8000_0000;
            model(a, b, eq, er, edbz);
            run_op(a, b, 0, q, r, dbz, lat, busy_ok);
            verify("rand", a, b, eq, er, edbz, q, r, dbz, lat, busy_ok);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
